qpmm_s2i_serial: RTL and testbench
==================================

# qpmm_s2i_serial

Limb-serial redundant-to-binary converter for the QPMM datapath. It accepts the 48-bit column-sum limbs of a QPMM accumulator row one per handshake and propagates carries across them. It emits the canonical binary integer `S0>>K + Σ_{i≥1} S_i·2^{L(i-1)}`, which is the same value the parallel final-addition stage forms. It sits on the QPMM output path wherever area matters more than latency, such as the readback of the stored accumulator row and the verification debug port.

## Interface
- `L`, default 16: limb radix in bits; limb i≥1 has weight 2^{L(i-1)}.
- `K`, default 16: low bits of limb 0 that are discarded (the q digit).
- `NLIMB`, default 20: limbs per operand, limb 0 through limb NLIMB-1; must be ≥2.
- `ZW`, default 352: result width; bits above ZW are truncated.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: `in_limb` is valid.
- `in_ready` out 1: the block accepts a limb this cycle.
- `in_limb` in 48: redundant limb, sent in order limb 0 first.
- `out_valid` out 1: `out_z` holds a complete result.
- `out_ready` in 1: the consumer takes the result.
- `out_z` out ZW: canonical integer result.

## Operation
- Operands are framed by count only; there is no last flag. The internal index `idx` (width clog2(NLIMB)) identifies the limb.
- Accumulator `cy` is 49 bits; `res` is ZW bits; `out_z = res`.
- FSM states IDLE, ACC, DONE. Reset state is IDLE with `idx=0`, `cy=0`, `res=0`.
- IDLE: `in_ready=1`, `out_valid=0`. On `in_valid` the block sets `cy ← in_limb[47:K]`, `res ← 0`, `idx ← 1`, then goes to ACC.
- ACC: `in_ready=1`, `out_valid=0`. On `in_valid` it computes `t = cy + in_limb` in 49 bits and writes `res[L(idx-1) +: L] ← t[L-1:0]`.
  - If `idx < NLIMB-1`: `cy ← t >> L`, `idx ← idx+1`, stay in ACC.
  - If `idx == NLIMB-1`: also write `res[L(NLIMB-1) +: 49-L] ← t >> L`, truncating any bits at or above ZW. Then `idx ← 0` and go to DONE.
- DONE: `in_ready=0`, `out_valid=1`, and `res` is held stable. On `out_ready` the block goes to IDLE. `in_valid` is ignored in DONE.
- Every write into `res` is silently truncated at ZW. There is no overflow flag.
- Input stalls: `in_valid=0` in IDLE or ACC holds all state. Gaps between limbs are unlimited.

## Timing
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from any input.
- Throughput and latency:
  - One limb per cycle is accepted while `in_valid` stays high.
  - `out_valid` rises in the cycle after the edge that accepts limb NLIMB-1.
  - Best case is NLIMB+1 cycles from limb 0 to `out_valid`.
- Each operand costs NLIMB accept cycles, one or more DONE cycles, and then IDLE. The minimum period is NLIMB+1 cycles.
- Output handshake:
  - The result transfers on the edge where `out_valid && out_ready`.
  - `out_ready` held high gives one DONE cycle.
  - `out_z` stays unchanged until the next limb 0 is accepted.
- Reset values: `out_valid=0`, `out_z=0`, `in_ready=1`. Asserting `rst` mid-operand or in DONE aborts immediately with no partial result. The limb presented in the first cycle after release is treated as limb 0.

## Test plan
- NLIMB=3, L=16, K=16, ZW=80; limbs 0x000000010000, 0x00000000FFFF, 0x000000000002 back-to-back → `out_valid` three cycles after the first accept, `out_z=0x30000`.
- Same config; limbs 0, 0xFFFFFFFFFFFF, 0xFFFFFFFFFFFF → `out_z=0x10000FFFFFFFEFFFF`, exercising a full-width carry.
- Same stimulus with ZW=48 → `out_z=0xFFFFFFFEFFFF`, exercising truncation.
- `in_valid` toggled 1,0,0,1,0,1 during an operand, and `out_ready` low for 5 cycles in DONE:
  - the result equals the gap-free result;
  - `in_ready=0` and `out_z` is stable throughout DONE;
  - the next operand is accepted the cycle after `out_ready`.
- `rst` pulsed after limb 1 is accepted, then a full new operand is sent:
  - `out_valid=0` and `out_z=0` during reset;
  - the new result is correct and the aborted limbs have no effect.
- Default config, 1000 random operands with random stalls on both sides → every result matches a reference model of `S0>>K + Σ S_i·2^{16(i-1)}` mod 2^352.

Source files
------------

// File: rtl/qpmm_s2i_serial.sv
// Limb-serial redundant-to-binary converter: folds 48-bit column-sum limbs into a
// canonical ZW-bit integer, one limb per accepted handshake, carrying between limbs.
module qpmm_s2i_serial #(
   parameter int L     = 16,
   parameter int K     = 16,
   parameter int NLIMB = 20,
   parameter int ZW    = 352
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [47:0]   in_limb,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [ZW-1:0] out_z
);

   localparam int IW = (NLIMB > 2) ? $clog2(NLIMB) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [IW-1:0] idx_reg, idx_next;
   logic [48:0]   cy_reg, cy_next;
   logic [ZW-1:0] res_reg, res_next;

   logic [48:0]   t;
   logic [48:0]   wr_val;
   logic [31:0]   pos;
   logic          last;

   assign t    = cy_reg + {1'b0, in_limb};
   assign last = (idx_reg == IW'(NLIMB - 1));
   assign pos  = 32'(L) * (32'(idx_reg) - 32'd1);

   // The final limb also deposits its carry-out directly above its own slice,
   // so the whole 49-bit sum lands at the same offset.
   assign wr_val = last ? t : (t & {{(49 - L){1'b0}}, {L{1'b1}}});

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cy_next    = cy_reg;
      res_next   = res_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cy_next    = 49'(in_limb >> K);
               res_next   = '0;
               idx_next   = IW'(1);
               state_next = ACC;
            end
         end
         ACC: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // Slices are disjoint and res starts cleared, so OR-ing is a write;
               // the cast truncates anything that would land at or above ZW.
               res_next = res_reg | (ZW'(wr_val) << pos);
               if (last) begin
                  idx_next   = '0;
                  state_next = DONE;
               end else begin
                  cy_next  = t >> L;
                  idx_next = idx_reg + IW'(1);
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         cy_reg    <= '0;
         res_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cy_reg    <= cy_next;
         res_reg   <= res_next;
      end
   end

   assign out_z = res_reg;

endmodule

// File: tb/tb_qpmm_s2i_serial.sv
// Bench for qpmm_s2i_serial: directed vectors on two 3-limb instances (ZW=80/48)
// and randomized operands with a reference-sum model on a default instance.
module tb_qpmm_s2i_serial;

   logic         clk;
   logic         rst;

   logic         a_in_valid, a_out_ready;
   logic [47:0]  a_in_limb;
   logic         a_in_ready, a_out_valid;
   logic [79:0]  a_out_z;
   logic         b_in_ready, b_out_valid;
   logic [47:0]  b_out_z;

   logic         c_in_valid, c_out_ready;
   logic [47:0]  c_in_limb;
   logic         c_in_ready, c_out_valid;
   logic [351:0] c_out_z;

   int n_tests = 0;
   int n_fail  = 0;
   logic [351:0] exp_q[$];

   qpmm_s2i_serial #(.L(16), .K(16), .NLIMB(3), .ZW(80)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_limb(a_in_limb),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_z(a_out_z)
   );

   qpmm_s2i_serial #(.L(16), .K(16), .NLIMB(3), .ZW(48)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(b_in_ready), .in_limb(a_in_limb),
      .out_valid(b_out_valid), .out_ready(a_out_ready), .out_z(b_out_z)
   );

   qpmm_s2i_serial dut_c (
      .clk(clk), .rst(rst),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_limb(c_in_limb),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_z(c_out_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [351:0] got, input logic [351:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Directed helpers start and end on a falling edge.
   task automatic a_send(input logic [47:0] v);
      a_in_valid = 1'b1;
      a_in_limb  = v;
      chk("a_in_ready", a_in_ready, 1);
      chk("b_in_ready", b_in_ready, 1);
      @(negedge clk);
   endtask

   task automatic a_idle();
      a_in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic a_take();
      chk("a_take_valid", a_out_valid, 1);
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      chk("a_after_take_valid", a_out_valid, 0);
      chk("a_after_take_ready", a_in_ready, 1);
   endtask

   task automatic c_driver();
      logic [47:0]  lv[20];
      logic [351:0] e;
      int           w;
      for (int op = 0; op < 1000; op++) begin
         for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) lv[i] = 48'hFFFF_FFFF_FFFF;
            else lv[i] = 48'({$urandom(), $urandom()});
         end
         e = 352'(lv[0] >> 16);
         for (int i = 1; i < 20; i++) e = e + (352'(lv[i]) << (16 * (i - 1)));
         exp_q.push_back(e);
         for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) begin
                  c_in_valid = 1'b0;
                  @(negedge clk);
               end
            end
            c_in_valid = 1'b1;
            c_in_limb  = lv[i];
            w = 0;
            while (!c_in_ready && w < 200) begin
               @(negedge clk);
               w++;
            end
            if (!c_in_ready) begin
               chk("c_in_timeout", 0, 1);
               c_in_valid = 1'b0;
               return;
            end
            @(negedge clk);
         end
      end
      c_in_valid = 1'b0;
   endtask

   task automatic c_monitor();
      int got = 0;
      int cyc = 0;
      while (got < 1000 && cyc < 90000) begin
         c_out_ready = ($urandom_range(0, 1) == 1);
         if (c_out_valid && c_out_ready) begin
            if (exp_q.size() == 0) chk("c_unexpected", 1, 0);
            else chk("c_rand", c_out_z, exp_q.pop_front());
            $display("[TB] random result %0d received", got);
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      c_out_ready = 1'b0;
      if (got < 1000) chk("c_timeout", 352'(got), 352'd1000);
   endtask

   initial begin
      rst = 1'b1;
      a_in_valid = 1'b0; a_in_limb = '0; a_out_ready = 1'b0;
      c_in_valid = 1'b0; c_in_limb = '0; c_out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_z", a_out_z, 0);
      chk("rst_a_ready", a_in_ready, 1);
      chk("rst_c_valid", c_out_valid, 0);
      chk("rst_c_ready", c_in_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back operand, result three edges after the first accept.
      a_send(48'h000000010000);
      chk("t1_valid_early0", a_out_valid, 0);
      a_send(48'h00000000FFFF);
      chk("t1_valid_early1", a_out_valid, 0);
      a_send(48'h000000000002);
      a_in_valid = 1'b0;
      chk("t1_valid", a_out_valid, 1);
      chk("t1_a_z", a_out_z, 80'h30000);
      chk("t1_b_z", b_out_z, 48'h30000);
      chk("t1_busy", a_in_ready, 0);
      a_take();
      $display("[TB] test1 done");

      // Full-width carry, and truncation on the narrow instance.
      a_send(48'h0);
      a_send(48'hFFFF_FFFF_FFFF);
      a_send(48'hFFFF_FFFF_FFFF);
      a_in_valid = 1'b0;
      chk("t2_a_z", a_out_z, 80'h1_0000_FFFF_FFFE_FFFF);
      chk("t2_b_z", b_out_z, 48'hFFFF_FFFE_FFFF);
      a_take();
      $display("[TB] test2 done");

      // Input gaps plus a stalled consumer.
      a_send(48'h000000010000);
      a_idle();
      a_idle();
      a_send(48'h00000000FFFF);
      a_idle();
      a_send(48'h000000000002);
      a_in_valid = 1'b0;
      chk("t3_valid", a_out_valid, 1);
      chk("t3_z", a_out_z, 80'h30000);
      for (int i = 0; i < 5; i++) begin
         a_in_valid = 1'b1;
         a_in_limb  = 48'hABCD_EF01_2345;
         chk("t3_hold_ready", a_in_ready, 0);
         chk("t3_hold_valid", a_out_valid, 1);
         chk("t3_hold_z", a_out_z, 80'h30000);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      a_take();
      chk("t3_z_after_take", a_out_z, 80'h30000);
      a_send(48'h0);
      a_send(48'hFFFF_FFFF_FFFF);
      a_send(48'hFFFF_FFFF_FFFF);
      a_in_valid = 1'b0;
      chk("t3_next_z", a_out_z, 80'h1_0000_FFFF_FFFE_FFFF);
      a_take();
      $display("[TB] test3 done");

      // Reset mid-operand discards the partial result.
      a_send(48'h0000FFFF0000);
      a_send(48'h000000001234);
      a_in_valid = 1'b0;
      chk("t4_partial", a_out_z, 80'h1233);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_rst_valid", a_out_valid, 0);
      chk("t4_rst_z", a_out_z, 0);
      chk("t4_rst_ready", a_in_ready, 1);
      chk("t4_rst_b_z", b_out_z, 0);
      rst = 1'b0;
      a_send(48'h000000010000);
      a_send(48'h00000000FFFF);
      a_send(48'h000000000002);
      a_in_valid = 1'b0;
      chk("t4_valid", a_out_valid, 1);
      chk("t4_z", a_out_z, 80'h30000);
      chk("t4_b_z", b_out_z, 48'h30000);
      a_take();
      $display("[TB] test4 done");

      fork
         c_driver();
         c_monitor();
      join

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
